// File: rtl/morra_driver_if.sv
// rtl/morra_driver_if.sv - judge-side bus of the MorraCinese driver
//
// Purpose : bundles the driver <-> judge signals.
// Signals : PRIMO[1:0]   player 1 move (00 none, 01 sasso, 10 carta, 11 forbice)
//           SECONDO[1:0] player 2 move, same encoding
//           INIZIA       configuration strobe; PRIMO/SECONDO carry the match count
//           MANCHE[1:0]  judge verdict (00 invalid, 01 primo, 10 secondo, 11 draw)
// Modports: master = driver, slave = judge.
interface morra_driver_if;
    logic [1:0] PRIMO;
    logic [1:0] SECONDO;
    logic       INIZIA;
    logic [1:0] MANCHE;

    modport master (output PRIMO, output SECONDO, output INIZIA, input MANCHE);
    modport slave  (input PRIMO, input SECONDO, input INIZIA, output MANCHE);
endinterface

// File: rtl/morra_driver.sv
// rtl/morra_driver.sv - self-play stimulus driver for the MorraCinese judge
//
// Purpose : configures the judge, plays both players with LFSR-driven legal
//           moves, samples the verdict every round and decides the partita.
// Ports   : clk, rst (sync, active high)
//           start        one-cycle pulse, accepted only in IDLE
//           num_partite  match count sent during CONFIG
//           judge        morra_driver_if.master (PRIMO/SECONDO/INIZIA out, MANCHE in)
//           busy         high from CONFIG through DONE
//           done         one-cycle pulse in DONE
//           winner       01 primo, 10 secondo, 11 draw; held until next start
//           manche_count valid rounds, invalid_count rounds judged 00
//           mismatch     (only with MORRA_DRIVER_CHECK_EN) sticky verdict disagreement
// Option  : define MORRA_DRIVER_CHECK_EN to add the verdict self-check.
module morra_driver #(
    parameter logic [7:0] SEED_1     = 8'hA5,
    parameter logic [7:0] SEED_2     = 8'h3C,
    parameter int         MIN_MANCHE = 4,
    parameter int         MAX_MANCHE = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [3:0]            num_partite,
    morra_driver_if.master        judge,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            winner,
    output logic [4:0]            manche_count,
    output logic [4:0]            invalid_count
`ifdef MORRA_DRIVER_CHECK_EN
    ,
    output logic                  mismatch
`endif
);

    localparam logic [4:0] MIN_M     = 5'(MIN_MANCHE);
    localparam logic [4:0] MAX_M     = 5'(MAX_MANCHE);
    localparam logic [4:0] INV_LIMIT = 5'd31;

    typedef enum logic [2:0] {IDLE, CONFIG, MOVE, RESULT, DONE} state_t;

    state_t state, state_nxt;

    logic [7:0] lfsr_1, lfsr_2;
    logic [1:0] m1, m2;
    logic [1:0] m1_q, m2_q;
    logic [4:0] wins_1, wins_2;
    logic [1:0] prev_winner, prev_move;

    logic [4:0]        manche_nxt, invalid_nxt, wins_1_nxt, wins_2_nxt;
    logic signed [5:0] score_diff;
    logic              decided;
    logic [1:0]        win_nxt;

    // Galois LFSR, x^8+x^6+x^5+x^4+1, shifting right.
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return s[0] ? ({1'b0, s[7:1]} ^ 8'hB8) : {1'b0, s[7:1]};
    endfunction

    // 01 -> 10 -> 11 -> 01
    function automatic logic [1:0] rotate(input logic [1:0] m);
        return (m == 2'b11) ? 2'b01 : m + 2'b01;
    endfunction

    function automatic logic [1:0] pick_move(input logic [7:0] s, input logic constrained,
                                             input logic [1:0] banned);
        logic [1:0] c;
        c = (s[1:0] == 2'b00) ? 2'b01 : s[1:0];
        return (constrained && c == banned) ? rotate(c) : c;
    endfunction

    assign m1 = pick_move(lfsr_1, prev_winner == 2'b01, prev_move);
    assign m2 = pick_move(lfsr_2, prev_winner == 2'b10, prev_move);

    // Counts as they will be after the current verdict; the exit decision
    // is taken on these so DONE is entered straight from RESULT.
    always_comb begin
        manche_nxt  = manche_count;
        invalid_nxt = invalid_count;
        wins_1_nxt  = wins_1;
        wins_2_nxt  = wins_2;
        case (judge.MANCHE)
            2'b00:   invalid_nxt = invalid_count + 5'd1;
            2'b01: begin
                manche_nxt = manche_count + 5'd1;
                wins_1_nxt = wins_1 + 5'd1;
            end
            2'b10: begin
                manche_nxt = manche_count + 5'd1;
                wins_2_nxt = wins_2 + 5'd1;
            end
            default: manche_nxt = manche_count + 5'd1;
        endcase
    end

    assign score_diff = $signed({1'b0, wins_1_nxt}) - $signed({1'b0, wins_2_nxt});

    always_comb begin
        decided = 1'b0;
        win_nxt = 2'b00;
        if (manche_nxt >= MIN_M && score_diff >= 6'sd2) begin
            decided = 1'b1;
            win_nxt = 2'b01;
        end else if (manche_nxt >= MIN_M && score_diff <= -6'sd2) begin
            decided = 1'b1;
            win_nxt = 2'b10;
        end else if (manche_nxt == MAX_M || invalid_nxt == INV_LIMIT) begin
            decided = 1'b1;
            win_nxt = 2'b11;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CONFIG;
            CONFIG:  state_nxt = MOVE;
            MOVE:    state_nxt = RESULT;
            RESULT:  state_nxt = decided ? DONE : MOVE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        judge.PRIMO   = 2'b00;
        judge.SECONDO = 2'b00;
        judge.INIZIA  = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        case (state)
            IDLE:   busy = 1'b0;
            CONFIG: begin
                judge.INIZIA  = 1'b1;
                judge.PRIMO   = num_partite[3:2];
                judge.SECONDO = num_partite[1:0];
            end
            MOVE: begin
                judge.PRIMO   = m1;
                judge.SECONDO = m2;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: LFSRs, scoreboard, legality memory
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_1        <= SEED_1;
            lfsr_2        <= SEED_2;
            m1_q          <= 2'b00;
            m2_q          <= 2'b00;
            wins_1        <= 5'd0;
            wins_2        <= 5'd0;
            prev_winner   <= 2'b00;
            prev_move     <= 2'b00;
            winner        <= 2'b00;
            manche_count  <= 5'd0;
            invalid_count <= 5'd0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    // A new partita starts with no legality constraint.
                    wins_1        <= 5'd0;
                    wins_2        <= 5'd0;
                    prev_winner   <= 2'b00;
                    prev_move     <= 2'b00;
                    winner        <= 2'b00;
                    manche_count  <= 5'd0;
                    invalid_count <= 5'd0;
                end
                MOVE: begin
                    m1_q   <= m1;
                    m2_q   <= m2;
                    lfsr_1 <= lfsr_step(lfsr_1);
                    lfsr_2 <= lfsr_step(lfsr_2);
                end
                RESULT: begin
                    manche_count  <= manche_nxt;
                    invalid_count <= invalid_nxt;
                    wins_1        <= wins_1_nxt;
                    wins_2        <= wins_2_nxt;
                    case (judge.MANCHE)
                        2'b01: begin
                            prev_winner <= 2'b01;
                            prev_move   <= m1_q;
                        end
                        2'b10: begin
                            prev_winner <= 2'b10;
                            prev_move   <= m2_q;
                        end
                        2'b11:   prev_winner <= 2'b00;
                        default: ;
                    endcase
                    if (decided) winner <= win_nxt;
                end
                default: ;
            endcase
        end
    end

`ifdef MORRA_DRIVER_CHECK_EN
    function automatic logic [1:0] expected_verdict(input logic [1:0] a, input logic [1:0] b,
                                                    input logic [1:0] pw, input logic [1:0] pm);
        if ((pw == 2'b01 && a == pm) || (pw == 2'b10 && b == pm)) return 2'b00;
        if (a == b) return 2'b11;
        if ((a == 2'b01 && b == 2'b11) || (a == 2'b10 && b == 2'b01) ||
            (a == 2'b11 && b == 2'b10)) return 2'b01;
        return 2'b10;
    endfunction

    // Legality state is unchanged between MOVE and RESULT, so it still
    // describes the moves held in m1_q/m2_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch <= 1'b0;
        end else if (state == IDLE && start) begin
            mismatch <= 1'b0;
        end else if (state == RESULT &&
                     judge.MANCHE != expected_verdict(m1_q, m2_q, prev_winner, prev_move)) begin
            mismatch <= 1'b1;
        end
    end
`endif

endmodule
